sub_word_engine: RTL and testbench
==================================

# sub_word_engine

Sequential, parametrised SubWord unit for the AES datapath. It accepts a block of NWORDS 32-bit words over a valid/ready handshake and optionally applies RotWord to each word. It then substitutes every byte through a time-multiplexed bank of LANES S-boxes and returns the result over a second valid/ready handshake. It serves both the key-expansion path (1 word, RotWord on) and the round datapath (4 words = full state SubBytes). Area is traded against latency through LANES.

## Interface
- NWORDS, default 4: number of 32-bit words per transaction; legal range 1..8.
- LANES, default 4: number of S-box instances, i.e. bytes substituted per cycle. Must be a power of two that divides 4*NWORDS; any other value is an elaboration error.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  engine can accept a request.
- in_data  input  32*NWORDS  word i at bits [32i+31:32i]; byte 0 is the LSB.
- in_rot  input  1  apply RotWord to each word before substitution.
- in_inv  input  1  use the inverse S-box (see Configuration).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32*NWORDS  substituted words, same layout as in_data.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into the work register and latch in_inv; clear byte pointer ptr to 0; go to BUSY.
  - If in_rot=1, capture each word w as {w[23:0],w[31:24]}; otherwise capture it unchanged.
- BUSY
  - in_ready=0.
  - Each cycle, bytes ptr..ptr+LANES-1 of the work register are replaced in place by S(byte), or by InvS(byte) when the latched inv is 1.
  - ptr advances by LANES each cycle.
  - On the cycle that processes the last group (ptr==4*NWORDS-LANES), go to DONE.
- DONE
  - out_valid=1 and out_data=work register.
  - out_data is held stable while out_valid&&!out_ready.
  - On out_ready=1, go to IDLE.
  - in_ready=0 in DONE, so there is no overlap of request and response.
- S-box lookup is combinational (256-entry ROM per lane). Lane k handles byte ptr+k.
- Mode inputs are sampled only at the accept edge. Changes to in_rot/in_inv/in_data while busy have no effect.
- Reset, asserted at any time including mid-BUSY or DONE: immediate return to IDLE. Work register, ptr and latched inv clear to 0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0.
- Define K = 4*NWORDS/LANES.
- Accept at edge 0. BUSY occupies edges 1..K. out_valid rises after edge K, giving a latency of K cycles from accept to out_valid.
- Minimum period between accepts is K+2 cycles: accept, K busy cycles, 1 DONE cycle with out_ready=1, back in IDLE.
- Boundary cases:
  - LANES=4*NWORDS gives K=1: a single BUSY cycle.
  - out_ready held high in advance: DONE lasts exactly one cycle.
  - out_ready asserted while out_valid=0: ignored.
- All outputs are registered or decoded from registered state only. There is no combinational path from in_* or out_ready to any output.

## Configuration
- SUBWORD_INV_EN defined:
  - Each lane includes an inverse S-box ROM and a mux.
  - in_inv=1 selects InvS.
- SUBWORD_INV_EN undefined:
  - No inverse ROMs are instantiated.
  - in_inv is ignored and the latched inv is tied to 0.
  - Every transaction uses the forward S-box.

## Test plan
- NWORDS=1, LANES=1, in_data=32'h59f67f73, rot=0, inv=0 -> out_data=32'hcb42d28f, with out_valid rising exactly 4 cycles after accept.
- NWORDS=2, LANES=2, in_data={32'h7a883b6d,32'h59f67f73} -> out_data={32'hdac4e23c,32'hcb42d28f} after 4 cycles; in_ready=0 throughout.
- NWORDS=1, LANES=4, in_data=32'h7a883b6d, rot=1 -> out_data=32'hc4e23cda after 1 cycle.
- in_data=32'hcb42d28f, inv=1:
  - With SUBWORD_INV_EN defined -> 32'h59f67f73.
  - Without SUBWORD_INV_EN -> 32'h1f2cb573.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data/out_valid stable; an in_valid pulse is not accepted. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset: assert rst_n=0 midway through BUSY -> out_valid=0, out_data=0, in_ready=1 immediately. A subsequent request completes with the correct result.

Source files
------------

// File: rtl/sub_word_engine_if.sv
// Request/response bundle for sub_word_engine.
// Request side: in_valid/in_ready, in_data, in_rot, in_inv.
// Response side: out_valid/out_ready, out_data.
// The master modport is the requester and consumer.
// The slave modport is the engine.
interface sub_word_engine_if #(
    parameter int NWORDS = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [32*NWORDS-1:0]  in_data;
    logic                  in_rot;
    logic                  in_inv;
    logic                  out_valid;
    logic                  out_ready;
    logic [32*NWORDS-1:0]  out_data;

    modport master (
        output in_valid, in_data, in_rot, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_rot, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sub_word_engine.sv
// Sequential AES SubWord/SubBytes engine with optional RotWord.
// It substitutes LANES bytes per cycle through time-multiplexed S-boxes.
// Ports: clk, rst_n (async, active low), bus (sub_word_engine_if.slave).
// Parameters: NWORDS (1..8) words per block.
// Parameters: LANES is the S-box count, a power of two dividing 4*NWORDS.
// Define SUBWORD_INV_EN to add inverse S-boxes selected by in_inv.
module sub_word_engine #(
    parameter int NWORDS = 4,
    parameter int LANES  = 4
) (
    input logic              clk,
    input logic              rst_n,
    sub_word_engine_if.slave bus
);
    localparam int NB = 4 * NWORDS;
    localparam int W  = 32 * NWORDS;
    localparam int PW = $clog2(NB);
    localparam logic [PW-1:0] LAST = PW'(NB - LANES);

    if (NWORDS < 1 || NWORDS > 8) begin : g_bad_nwords
        $error("sub_word_engine: NWORDS must be 1..8");
    end
    if (LANES < 1 || (LANES & (LANES - 1)) != 0 || (NB % LANES) != 0)
    begin : g_bad_lanes
        $error("sub_word_engine: LANES must be a power of two dividing 4*NWORDS");
    end

    localparam logic [0:255][7:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SUBWORD_INV_EN
    localparam logic [0:255][7:0] INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   work_q;
    logic [W-1:0]   work_sub;
    logic [W-1:0]   cap;
    logic [PW-1:0]  ptr_q;
    logic [7:0]     lane_in  [LANES];
    logic [7:0]     lane_out [LANES];

`ifdef SUBWORD_INV_EN
    logic inv_q;
`else
    logic unused_inv;
    assign unused_inv = bus.in_inv;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)    state_d = BUSY;
            BUSY:    if (ptr_q == LAST)   state_d = DONE;
            DONE:    if (bus.out_ready)   state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_data  = (state_q == DONE) ? work_q : '0;
    end

    // RotWord is a left byte rotation: byte 3 moves to byte 0.
    always_comb begin
        cap = bus.in_data;
        for (int i = 0; i < NWORDS; i++) begin
            if (bus.in_rot) begin
                cap[32*i +: 32] = {bus.in_data[32*i +: 24],
                                   bus.in_data[32*i+24 +: 8]};
            end
        end
    end

    // Lane k always serves byte ptr+k of the current group.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_in[k] = work_q[8*(int'(ptr_q)+k) +: 8];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef SUBWORD_INV_EN
        assign lane_out[k] = inv_q ? INV[lane_in[k]] : FWD[lane_in[k]];
`else
        assign lane_out[k] = FWD[lane_in[k]];
`endif
    end

    always_comb begin
        work_sub = work_q;
        for (int k = 0; k < LANES; k++) begin
            work_sub[8*(int'(ptr_q)+k) +: 8] = lane_out[k];
        end
    end

    // ptr returns to 0 after the last group so lane indices stay in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            ptr_q  <= '0;
`ifdef SUBWORD_INV_EN
            inv_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_q <= cap;
                        ptr_q  <= '0;
`ifdef SUBWORD_INV_EN
                        inv_q  <= bus.in_inv;
`endif
                    end
                end
                BUSY: begin
                    work_q <= work_sub;
                    if (ptr_q == LAST) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= ptr_q + PW'(LANES);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_word_engine.sv
// Directed bench for sub_word_engine across three configurations.
// A: 1 word/1 lane, B: 2 words/2 lanes, C: 1 word/4 lanes.
module tb_sub_word_engine;
    localparam int LIMIT = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sub_word_engine_if #(.NWORDS(1)) ifa ();
    sub_word_engine_if #(.NWORDS(2)) ifb ();
    sub_word_engine_if #(.NWORDS(1)) ifc ();

    sub_word_engine #(.NWORDS(1), .LANES(1)) ua (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    sub_word_engine #(.NWORDS(2), .LANES(2)) ub (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    sub_word_engine #(.NWORDS(1), .LANES(4)) uc (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave));

`ifdef SUBWORD_INV_EN
    localparam logic [63:0] E3  = 64'h59f67f73;
    localparam logic [63:0] E7  = 64'h00000000;
    localparam logic [63:0] E9  = 64'h6ad53009_f67f7359;
    localparam logic [63:0] E12 = 64'h7d7d7d7d;
`else
    localparam logic [63:0] E3  = 64'h1f2cb573;
    localparam logic [63:0] E7  = 64'hfbfbfbfb;
    localparam logic [63:0] E9  = 64'h777bf27c_2cb5731f;
    localparam logic [63:0] E12 = 64'h16161616;
`endif

    typedef struct {
        int          id;
        logic [63:0] din;
        bit          rot;
        bit          inv;
        logic [63:0] exp;
        int          k;
    } vec_t;

    vec_t vt [13];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int id, input bit v, input logic [63:0] d,
                          input bit rot, input bit inv);
        case (id)
            0: begin
                ifa.in_valid = v; ifa.in_data = d[31:0];
                ifa.in_rot = rot; ifa.in_inv = inv;
            end
            1: begin
                ifb.in_valid = v; ifb.in_data = d;
                ifb.in_rot = rot; ifb.in_inv = inv;
            end
            default: begin
                ifc.in_valid = v; ifc.in_data = d[31:0];
                ifc.in_rot = rot; ifc.in_inv = inv;
            end
        endcase
    endtask

    task automatic set_ordy(input int id, input bit r);
        case (id)
            0:       ifa.out_ready = r;
            1:       ifb.out_ready = r;
            default: ifc.out_ready = r;
        endcase
    endtask

    function automatic logic ov(input int id);
        case (id)
            0:       return ifa.out_valid;
            1:       return ifb.out_valid;
            default: return ifc.out_valid;
        endcase
    endfunction

    function automatic logic ir(input int id);
        case (id)
            0:       return ifa.in_ready;
            1:       return ifb.in_ready;
            default: return ifc.in_ready;
        endcase
    endfunction

    function automatic logic [63:0] od(input int id);
        case (id)
            0:       return {32'h0, ifa.out_data};
            1:       return ifb.out_data;
            default: return {32'h0, ifc.out_data};
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge with the target engine idle.
    task automatic xact(input int id, input logic [63:0] din, input bit rot,
                        input bit inv, output logic [63:0] dout,
                        output int lat, output bit busy_ok);
        set_in(id, 1'b1, din, rot, inv);
        cyc();
        set_in(id, 1'b0, ~din, ~rot, ~inv);
        lat = 0;
        busy_ok = 1'b1;
        while (!ov(id) && lat < LIMIT) begin
            if (ir(id)) busy_ok = 1'b0;
            cyc();
            lat++;
        end
        dout = od(id);
    endtask

    task automatic release_out(input int id);
        set_ordy(id, 1'b1);
        cyc();
        set_ordy(id, 1'b0);
    endtask

    logic [63:0] dout;
    int          lat;
    bit          bok;

    initial begin
        vt[0]  = '{0, 64'h59f67f73, 0, 0, 64'hcb42d28f, 4};
        vt[1]  = '{0, 64'h7a883b6d, 0, 0, 64'hdac4e23c, 4};
        vt[2]  = '{0, 64'h7a883b6d, 1, 0, 64'hc4e23cda, 4};
        vt[3]  = '{0, 64'hcb42d28f, 0, 1, E3,           4};
        vt[4]  = '{0, 64'h00000000, 0, 0, 64'h63636363, 4};
        vt[5]  = '{0, 64'hffffffff, 0, 0, 64'h16161616, 4};
        vt[6]  = '{0, 64'h01020304, 1, 0, 64'h777bf27c, 4};
        vt[7]  = '{0, 64'h63636363, 0, 1, E7,           4};
        vt[8]  = '{1, 64'h7a883b6d_59f67f73, 0, 0,
                   64'hdac4e23c_cb42d28f, 4};
        vt[9]  = '{1, 64'h01020304_cb42d28f, 1, 1, E9, 4};
        vt[10] = '{2, 64'h7a883b6d, 1, 0, 64'hc4e23cda, 1};
        vt[11] = '{2, 64'h00000000, 0, 0, 64'h63636363, 1};
        vt[12] = '{2, 64'hffffffff, 0, 1, E12,          1};

        for (int i = 0; i < 3; i++) begin
            set_in(i, 1'b0, 64'h0, 1'b0, 1'b0);
            set_ordy(i, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d_in_ready", i), 64'(ir(i)), 64'h1);
            check($sformatf("rst%0d_out_valid", i), 64'(ov(i)), 64'h0);
            check($sformatf("rst%0d_out_data", i), od(i), 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 13; i++) begin
            xact(vt[i].id, vt[i].din, vt[i].rot, vt[i].inv, dout, lat, bok);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].k));
            check($sformatf("v%0d_data", i), dout, vt[i].exp);
            check($sformatf("v%0d_busy_ready", i), 64'(bok), 64'h1);
            release_out(vt[i].id);
            check($sformatf("v%0d_idle_ready", i), 64'(ir(vt[i].id)), 64'h1);
            check($sformatf("v%0d_idle_valid", i), 64'(ov(vt[i].id)), 64'h0);
        end

        // Backpressure: result held, stray request ignored.
        xact(0, 64'h59f67f73, 1'b0, 1'b0, dout, lat, bok);
        check("bp_data", dout, 64'hcb42d28f);
        for (int c = 0; c < 5; c++) begin
            set_in(0, c == 2, 64'h0, 1'b0, 1'b0);
            cyc();
            check($sformatf("bp%0d_valid", c), 64'(ov(0)), 64'h1);
            check($sformatf("bp%0d_data", c), od(0), 64'hcb42d28f);
            check($sformatf("bp%0d_in_ready", c), 64'(ir(0)), 64'h0);
        end
        set_in(0, 1'b0, 64'h0, 1'b0, 1'b0);
        release_out(0);
        check("bp_rel_ready", 64'(ir(0)), 64'h1);
        check("bp_rel_valid", 64'(ov(0)), 64'h0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            check($sformatf("bp_idle%0d_ready", c), 64'(ir(0)), 64'h1);
            check($sformatf("bp_idle%0d_valid", c), 64'(ov(0)), 64'h0);
        end

        // out_ready held high in advance: DONE lasts one cycle.
        for (int id = 0; id < 3; id += 2) begin
            set_ordy(id, 1'b1);
            xact(id, 64'h7a883b6d, 1'b1, 1'b0, dout, lat, bok);
            check($sformatf("adv%0d_latency", id), 64'(lat),
                  (id == 0) ? 64'd4 : 64'd1);
            check($sformatf("adv%0d_data", id), dout, 64'hc4e23cda);
            cyc();
            check($sformatf("adv%0d_valid_gone", id), 64'(ov(id)), 64'h0);
            check($sformatf("adv%0d_ready_back", id), 64'(ir(id)), 64'h1);
            set_ordy(id, 1'b0);
        end

        // Reset midway through BUSY.
        set_in(0, 1'b1, 64'h59f67f73, 1'b0, 1'b0);
        cyc();
        set_in(0, 1'b0, 64'h0, 1'b0, 1'b0);
        cyc();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstbusy_in_ready", 64'(ir(0)), 64'h1);
        check("rstbusy_out_valid", 64'(ov(0)), 64'h0);
        check("rstbusy_out_data", od(0), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("rstbusy_stay_idle", 64'(ir(0)), 64'h1);
        xact(0, 64'h7a883b6d, 1'b0, 1'b0, dout, lat, bok);
        check("post_rst_latency", 64'(lat), 64'd4);
        check("post_rst_data", dout, 64'hdac4e23c);

        // Reset while holding a result in DONE.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstdone_out_valid", 64'(ov(0)), 64'h0);
        check("rstdone_out_data", od(0), 64'h0);
        check("rstdone_in_ready", 64'(ir(0)), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        xact(2, 64'h59f67f73, 1'b0, 1'b0, dout, lat, bok);
        check("post_rst2_data", dout, 64'hcb42d28f);
        release_out(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
